mdu_iter: RTL
=============

// Module: mdu_iter
// PURPOSE
//  Parametrised iterative multiply/divide unit for the EX stage of the pipelined core.
//  - Executes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
//  - Exposes a start/busy/done handshake and a stall request that drives the PC/IFID hold path.
//  - Accepts a cancel input from the branch/jump flush logic.
// PARAMETERS
//  WIDTH       32  operand width; HI and LO are each WIDTH bits
//  CNT_W       6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      asynchronous, active-low; all state cleared while low
//  start      in   1      EX-stage request; qualified by op
//  op         in   3      0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 = no-op
//  rs_val     in   WIDTH  forwarded operand A (dividend / multiplicand / MTxx data)
//  rt_val     in   WIDTH  forwarded operand B (divisor / multiplier)
//  cancel     in   1      flush of the instruction owning the current/starting operation
//  rd_hilo    in   1      MFHI/MFLO currently in EX
//  hi         out  WIDTH  architectural HI
//  lo         out  WIDTH  architectural LO
//  busy       out  1      operation in flight
//  done       out  1      one-cycle pulse: HI/LO just updated by MULT/DIV
//  stall      out  1      pipeline hold request
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, counter=0; hi, lo, busy, done = 0; stall=0.
//  FSM states: IDLE -> CALC -> FIX -> IDLE.
//  IDLE: start=1 with op 0..3 and cancel=0 at edge E0.
//   - Latch |A| and |B|; for op 0 and 2, also latch the result signs.
//   - Go to CALC with counter=WIDTH-1.
//  IDLE: start=1 with op 4/5 and cancel=0 writes hi/lo=rs_val at that edge.
//   - No busy, no done pulse.
//  IDLE: op 6/7 is ignored.
//  CALC: one iteration per cycle, WIDTH cycles total.
//   - Multiply: radix-2 shift-add into a 2*WIDTH-bit accumulator.
//   - Divide: restoring shift-subtract; quotient in low half, remainder in high half.
//   - Counter decrements each cycle; at 0 go to FIX.
//  FIX (1 cycle): apply the sign correction, then write hi/lo.
//   - MULT: negate the full 2*WIDTH product if the operand signs differ.
//   - DIV: the quotient takes sign(A)^sign(B); the remainder takes sign(A).
//   - Go to IDLE; done=1 in the following cycle only.
//  Timing: busy is high for exactly WIDTH+1 cycles after E0 (CALC + FIX).
//   - hi/lo hold the new values and done=1 in cycle WIDTH+2 after E0.
//  hi/lo are never partially updated; old values remain visible while busy.
//  stall = busy & (start | rd_hilo), combinational from registered busy.
//   - start while busy is never accepted; it must be held by the pipeline until busy=0.
//  Divide by zero (B=0): LO = all ones, HI = A (unsigned view of A for DIVU). Same latency.
//  Signed overflow: DIV of MIN_INT by -1 gives LO=MIN_INT, HI=0. No trap.
//  cancel=1 while busy:
//   - Return to IDLE at the next edge; busy=0 the next cycle.
//   - hi/lo are unchanged and no done pulse occurs.
//  cancel=1 together with start in IDLE: nothing starts; hi/lo are unchanged.
//  cancel in the FIX cycle: the write is suppressed.
//  reset asserted mid-operation: immediate abort to IDLE; hi=lo=0.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles; done in cycle 34; HI=0xFFFFFFFE, LO=0x00000001.
//  MULT -7*3 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  DIVU 100/0 -> LO=0xFFFFFFFF, HI=100. DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  MTHI 0x1234 then MFHI (rd_hilo=1) while idle -> hi=0x1234 next cycle; stall=0 throughout.
//  DIVU started, cancel in cycle 10 -> busy=0 by cycle 11; done never pulses; hi/lo keep prior values.
//  rd_hilo=1 during MULT -> stall=1 until busy falls; reset low at cycle 5 -> hi=lo=0, busy=0 at once.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add MULT/MULTU and restoring DIV/DIVU into HI/LO,
// with MTHI/MTLO writes, a stall request for the fetch/decode hold path and flush cancel.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             cancel,
    input  logic             rd_hilo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_e;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opd_q;
    logic                 is_div_q, neg_p_q, neg_r_q, divz_q, done_q;
    logic [WIDTH-1:0]     hi_q, lo_q;

    logic                 start_md, start_mt, is_signed;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_abs, b_abs;
    logic [WIDTH:0]       mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0]   mul_next, div_next, prod;
    logic [WIDTH-1:0]     quo, rem;
    logic [WIDTH-1:0]     res_hi, res_lo;

    assign start_md  = start & ~cancel & ~op[2];
    assign start_mt  = start & ~cancel & (op == 3'd4 || op == 3'd5);
    assign is_signed = (op == 3'd0) || (op == 3'd2);
    assign a_neg     = is_signed & rs_val[WIDTH-1];
    assign b_neg     = is_signed & rt_val[WIDTH-1];
    assign a_abs     = a_neg ? -rs_val : rs_val;
    assign b_abs     = b_neg ? -rt_val : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}; shift right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend/quotient}; shift left, trial-subtract divisor.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, opd_q};
    assign div_next = {(diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]),
                       acc_q[WIDTH-2:0], ~diff[WIDTH]};

    assign prod = neg_p_q ? -acc_q : acc_q;
    assign quo  = divz_q ? {WIDTH{1'b1}} : (neg_p_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    assign rem  = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            res_hi = rem;
            res_lo = quo;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_md) state_d = S_CALC;
            S_CALC: begin
                if (cancel)              state_d = S_IDLE;
                else if (cnt_q == '0)    state_d = S_FIX;
            end
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        stall     = busy & (start | rd_hilo);
        dbg_state = state_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            divz_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= (state_q == S_FIX) && !cancel;
            case (state_q)
                S_IDLE: begin
                    if (start_md) begin
                        is_div_q <= op[1];
                        opd_q    <= op[1] ? b_abs : a_abs;
                        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                        neg_p_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                        divz_q   <= op[1] && (rt_val == '0);
                        cnt_q    <= CNT_INIT;
                    end else if (start_mt) begin
                        if (op[0]) lo_q <= rs_val;
                        else       hi_q <= rs_val;
                    end
                end
                S_CALC: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    if (cancel)            cnt_q <= '0;
                    else if (cnt_q != '0)  cnt_q <= cnt_q - CNT_ONE;
                end
                S_FIX: begin
                    cnt_q <= '0;
                    if (!cancel) begin
                        hi_q <= res_hi;
                        lo_q <= res_lo;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;
endmodule
